// File: rtl/keypad_emulator_pkg.sv
// keypad_pkg: shared keypad FSM states, hex key layout and line polarities
package keypad_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } st_e;
  // Indexed by key value; row 0 is the top row, col 0 the leftmost column
  localparam logic [15:0][1:0] KEY_ROW = {
    2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2,
    2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3
  };
  localparam logic [15:0][1:0] KEY_COL = {
    2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1,
    2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd1
  };
  localparam logic       ROW_ACTIVE = 1'b1;
  localparam logic       COL_ACTIVE = 1'b0;
  localparam logic [3:0] COL_OPEN   = 4'b1111;
endpackage

// File: rtl/keypad_emulator_key_encode.sv
// key_encode: hex key to one-hot row and column, inverse of the scanner decode
module key_encode
  import keypad_pkg::*;
(
  input  logic [3:0] i_key,
  output logic [3:0] o_row,
  output logic [3:0] o_col
);
  assign o_row = 4'b1000 >> KEY_ROW[i_key];
  assign o_col = 4'b1000 >> KEY_COL[i_key];
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: plays one queued key press as bounce/hold/bounce/gap onto the column lines
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 8,
  parameter int BOUNCE_PERIOD = 2,
  parameter int HOLD_CYCLES   = 20,
  parameter int GAP_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  input  logic [3:0] key,
  input  logic       press_req,
  output logic       ready,
  output logic       done,
  output logic [3:0] columns
);
  localparam int MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam logic [CW-1:0] B_LAST = CW'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  st_e           r_state;
  logic [CW-1:0] r_cnt;
  logic          r_contact;
  logic          r_ready;
  logic          r_done;
  logic [3:0]    r_key;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_lvl;
  logic [3:0]    w_row;
  logic [3:0]    w_col;
  logic [3:0]    w_rows_on;
  assign w_cnt_nxt = r_cnt + CW'(1);
  // contact level for the next bounce cycle: closed on even multiples of the period
  assign w_lvl = ((w_cnt_nxt / CW'(BOUNCE_PERIOD)) & CW'(1)) == '0;
  key_encode u_enc (
    .i_key(r_key),
    .o_row(w_row),
    .o_col(w_col)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_contact <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_key     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (press_req) begin
          r_key     <= key;
          r_cnt     <= '0;
          r_contact <= 1'b1;
          r_ready   <= 1'b0;
          r_state   <= (BOUNCE_CYCLES == 0) ? ST_HOLD : ST_BOUNCE_IN;
        end
        ST_BOUNCE_IN: begin
          r_cnt     <= (r_cnt == B_LAST) ? '0 : w_cnt_nxt;
          r_contact <= (r_cnt == B_LAST) || w_lvl;
          if (r_cnt == B_LAST) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          r_cnt     <= (r_cnt == H_LAST) ? '0 : w_cnt_nxt;
          r_contact <= (r_cnt != H_LAST) || (BOUNCE_CYCLES != 0);
          if (r_cnt == H_LAST) r_state <= (BOUNCE_CYCLES == 0) ? ST_GAP : ST_BOUNCE_OUT;
        end
        ST_BOUNCE_OUT: begin
          r_cnt     <= (r_cnt == B_LAST) ? '0 : w_cnt_nxt;
          r_contact <= (r_cnt != B_LAST) && w_lvl;
          if (r_cnt == B_LAST) r_state <= ST_GAP;
        end
        ST_GAP: begin
          r_cnt <= (r_cnt == G_LAST) ? '0 : w_cnt_nxt;
          if (r_cnt == G_LAST) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign w_rows_on = ROW_ACTIVE ? rows : ~rows;
  assign columns   = (r_contact && |(w_rows_on & w_row)) ? (COL_ACTIVE ? w_col : ~w_col) : COL_OPEN;
  assign ready     = r_ready;
  assign done      = r_done;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed and random key presses checked against a timeline model
module tb_keypad_emulator;
  localparam int B = 8;
  localparam int P = 2;
  localparam int H = 20;
  localparam int G = 4;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] key;
  logic       req0, req1;
  logic       rdy0, done0, rdy1, done1;
  logic [3:0] cols0, cols1;
  int checks = 0;
  int failures = 0;
  int lay [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  always #5 clk = ~clk;
  keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(P), .HOLD_CYCLES(H), .GAP_CYCLES(G)) u_dut0 (
    .clk(clk), .reset(reset), .rows(rows), .key(key), .press_req(req0),
    .ready(rdy0), .done(done0), .columns(cols0)
  );
  keypad_emulator #(.BOUNCE_CYCLES(B), .BOUNCE_PERIOD(P), .HOLD_CYCLES(H), .GAP_CYCLES(G)) u_dut1 (
    .clk(clk), .reset(reset), .rows(rows), .key(key), .press_req(req1),
    .ready(rdy1), .done(done1), .columns(cols1)
  );
  // contact level i cycles into a press (i=0 is the cycle after acceptance)
  function automatic bit exp_contact(int b, int i);
    if (i < b) return ((i / P) % 2) == 0;
    if (i < b + H) return 1'b1;
    if (i < 2 * b + H) return (((i - b - H) / P) % 2) == 0;
    return 1'b0;
  endfunction
  function automatic logic [3:0] exp_cols(logic [3:0] k, logic [3:0] r, bit c);
    logic [3:0] v = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (lay[rr][cc] == int'(k) && c && r[3-rr]) v[3-cc] = 1'b0;
    return v;
  endfunction
  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic accept(int d, logic [3:0] k);
    check("ready_before_req", {3'b0, d ? rdy1 : rdy0}, 4'b0001);
    key = k;
    if (d != 0) req1 = 1'b1; else req0 = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic body(int d, logic [3:0] k, bit chain, int rmode);
    int b = (d != 0) ? B : 0;
    int dur = 2 * b + H + G;
    for (int i = 0; i < dur; i++) begin
      if (!chain) begin req0 = 1'b0; req1 = 1'b0; end
      key  = 4'($urandom);
      rows = (rmode < 0) ? 4'($urandom) : rmode[3:0];
      #1;
      check("columns", d ? cols1 : cols0, exp_cols(k, rows, exp_contact(b, i)));
      check("ready_busy", {3'b0, d ? rdy1 : rdy0}, 4'b0000);
      check("done_busy", {3'b0, d ? done1 : done0}, 4'b0000);
      @(posedge clk); #1;
    end
    rows = 4'($urandom);
    #1;
    check("done_pulse", {3'b0, d ? done1 : done0}, 4'b0001);
    check("ready_done", {3'b0, d ? rdy1 : rdy0}, 4'b0001);
    check("columns_done", d ? cols1 : cols0, 4'b1111);
  endtask
  initial begin
    reset = 1'b1; rows = 4'b1000; key = 4'h0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cols0", cols0, 4'b1111);
    check("rst_cols1", cols1, 4'b1111);
    check("rst_ready", {2'b0, rdy1, rdy0}, 4'b0011);
    check("rst_done", {2'b0, done1, done0}, 4'b0000);
    reset = 1'b0;
    @(posedge clk); #1;
    accept(0, 4'h5); body(0, 4'h5, 1'b0, 4);
    @(posedge clk); #1;
    check("done_width0", {3'b0, done0}, 4'b0000);
    accept(0, 4'h5); body(0, 4'h5, 1'b0, 8);
    @(posedge clk); #1;
    accept(1, 4'hA); body(1, 4'hA, 1'b0, 8);
    @(posedge clk); #1;
    check("done_width1", {3'b0, done1}, 4'b0000);
    accept(1, 4'h0); body(1, 4'h0, 1'b0, 15);
    accept(1, 4'h0); body(1, 4'h0, 1'b0, 0);
    @(posedge clk); #1;
    accept(1, 4'h3); body(1, 4'h3, 1'b1, -1);
    accept(1, 4'hD); body(1, 4'hD, 1'b0, -1);
    @(posedge clk); #1;
    for (int n = 0; n < 8; n++) begin
      int d = int'($urandom_range(0, 1));
      logic [3:0] k = 4'($urandom);
      accept(d, k);
      body(d, k, 1'($urandom), -1);
      req0 = 1'b0; req1 = 1'b0;
    end
    @(posedge clk); #1;
    accept(1, 4'h9);
    req1 = 1'b0; rows = 4'b1111;
    repeat (B + 5) begin @(posedge clk); #1; end
    check("hold_9", cols1, exp_cols(4'h9, 4'b1111, 1'b1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_cols", cols1, 4'b1111);
    check("rst_mid_ready", {3'b0, rdy1}, 4'b0001);
    check("rst_mid_done", {3'b0, done1}, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      rows = 4'($urandom);
      #1;
      check("post_rst_done", {3'b0, done1}, 4'b0000);
      check("post_rst_cols", cols1, 4'b1111);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
